addr_stack_ctrl: RTL
====================

Name: addr_stack_ctrl

Overview:
Program-address controller for the 8008-style core. It owns the 8-entry × 14-bit address stack, in which the active entry is the PC. It sequences increment, jump, call, return and restart operations requested by the fsm/decoder. It also drives the low and high address bytes onto the outgoing data bus during T1/T2.

Parameters:
AW, 14, program address width
DEPTH, 8, stack entries including active PC (power of 2)
PTR_W, $clog2(DEPTH), stack pointer width

Ports:
clk  input  1  clock
rst  input  1  synchronous active-high reset
op_valid  input  1  op is applied this cycle
op  input  3  addr_op_t: NOP, INC, LD_LO, LD_HI, JUMP, CALL, RET, RST
cond_ok  input  1  condition-flag result; gates JUMP/CALL/RET
data_in  input  8  operand byte for LD_LO/LD_HI
rst_vec  input  3  restart vector AAA for RST
out_sel  input  2  addr_sel_t: NONE, LOW, HIGH
cycle_type  input  2  bits D7:D6 emitted with high byte (PCI=00, PCR=10, PCC=01, PCW=11)
addr_out  output  8  address byte to bus
addr_oe  output  1  addr_out valid/drive enable
pc  output  AW  current PC = stack[sp]
sp  output  PTR_W  stack pointer
depth  output  PTR_W+1  valid return levels, 0..DEPTH-1
ovf  output  1  sticky: push overwrote oldest entry
unf  output  1  sticky: pop with no saved level

Behaviour:
- Reset (rst=1 at clk edge): all stack entries=0, sp=0, depth=0, tmp=0, ovf=unf=0. After reset pc=0 and addr_oe=0. Reset overrides any op in the same cycle. Reset mid-sequence (after LD_LO, before JUMP) discards tmp.
- All ops take effect at the clk edge where op_valid=1. Results are visible the next cycle, so there is one op per cycle and no busy signal. op_valid=0 or op=NOP: no state change.
- INC: stack[sp] <= stack[sp]+1 mod 2^AW. Wrap: 0x3FFF -> 0x0000.
- LD_LO: tmp[7:0] <= data_in.
- LD_HI: tmp[AW-1:8] <= data_in[AW-9:0]. Upper data_in bits are ignored.
- JUMP: if cond_ok, stack[sp] <= tmp. Otherwise no change.
- CALL: if cond_ok, sp <= sp+1 mod DEPTH, stack[sp+1] <= tmp, and depth increments, saturating at DEPTH-1. If depth was DEPTH-1, set ovf and let the oldest entry be overwritten (8008 wrap semantics). If cond_ok=0, no change.
- RET: if cond_ok, sp <= sp-1 mod DEPTH and depth decrements. If depth was 0, set unf, still move sp (wrap) and keep depth at 0. If cond_ok=0, no change.
- RST: unconditional push with target {0…0, rst_vec, 3'b000}, e.g. vec=5 -> 0x0028. depth/ovf rules are the same as CALL.
- The return address is the already-incremented PC left in the old stack slot. The controller does not adjust it.
- Undefined op encodings behave as NOP.
- Address output is combinational from registered state:
  - out_sel=LOW: addr_out=pc[7:0], addr_oe=1.
  - out_sel=HIGH: addr_out={cycle_type, pc[13:8]}, addr_oe=1.
  - out_sel=NONE: addr_out=0, addr_oe=0.
- An op and out_sel in the same cycle: the output shows the pre-op pc.
- ovf/unf stay set until rst.

Decomposition:
- Shared package (internal_defines.vh):
  - addr_op_t enum (3 bits).
  - addr_sel_t enum (2 bits).
  - cycle-type constants PCI/PCR/PCC/PCW.
  - RST vector shift constant.
- Sub-module addr_stack_mem: DEPTH×AW synchronous-write, async-read array, with read port at sp and write port addr/data/we.
- The top level holds sp, depth, tmp, flags, op decode and the output mux.

Test Plan:
1. Reset then INC×3; out_sel=LOW then HIGH with cycle_type=PCI -> addr_out=0x03, then 0x00, addr_oe=1; pc=0x0003.
2. pc=0x3FFF, INC -> pc=0x0000, sp unchanged, no flags.
3. LD_LO 0x34, LD_HI 0xD2, CALL cond_ok=1 from pc=0x0105 -> sp=1, pc=0x1234 (upper data bits dropped), depth=1. RET -> pc=0x0105, sp=0, depth=0.
4. CALL/JUMP/RET with cond_ok=0 -> pc, sp, depth unchanged. A following JUMP cond_ok=1 loads the tmp held from before.
5. 8 consecutive RST vec=7 from reset -> depth saturates at 7 with ovf=1 on the 8th, sp=0 (wrapped), pc=0x0038. RET at depth 0 after rst -> unf=1, sp=7.
6. CALL plus out_sel=HIGH, cycle_type=PCR, same cycle -> addr_out shows the old high byte |0x80. rst asserted with LD_HI -> tmp=0, pc=0, addr_oe=0 next cycle.

Source files
------------

// File: rtl/addr_stack_ctrl_pkg.sv
// Shared types and constants for the program-address controller:
// op and output-select encodings, bus cycle-type codes, restart vector shift.
package addr_stack_ctrl_pkg;

   typedef enum logic [2:0] {
      OP_NOP   = 3'd0,
      OP_INC   = 3'd1,
      OP_LD_LO = 3'd2,
      OP_LD_HI = 3'd3,
      OP_JUMP  = 3'd4,
      OP_CALL  = 3'd5,
      OP_RET   = 3'd6,
      OP_RST   = 3'd7
   } addr_op_t;

   typedef enum logic [1:0] {
      SEL_NONE = 2'd0,
      SEL_LOW  = 2'd1,
      SEL_HIGH = 2'd2
   } addr_sel_t;

   // Cycle-type codes ride in D7:D6 of the high address byte
   localparam logic [1:0] CYC_PCI = 2'b00;
   localparam logic [1:0] CYC_PCR = 2'b10;
   localparam logic [1:0] CYC_PCC = 2'b01;
   localparam logic [1:0] CYC_PCW = 2'b11;

   localparam int RST_VEC_SHIFT = 3;

endpackage

// File: rtl/addr_stack_ctrl_mem.sv
// Address stack storage: synchronous write, asynchronous read.
// The read port is tied to sp by the top, so rd_data is the live PC.
module addr_stack_ctrl_mem
   import addr_stack_ctrl_pkg::*;
#(
   parameter int AW    = 14,
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PTR_W-1:0] rd_addr,
   output logic [AW-1:0]    rd_data,
   input  logic             we,
   input  logic [PTR_W-1:0] wr_addr,
   input  logic [AW-1:0]    wr_data
);

   logic [AW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (we) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/addr_stack_ctrl.sv
// Program-address controller: sequences INC/LD/JUMP/CALL/RET/RST on the
// 8-level address stack and drives the address bytes onto the bus.
module addr_stack_ctrl
   import addr_stack_ctrl_pkg::*;
#(
   parameter int AW    = 14,
   parameter int DEPTH = 8,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             op_valid,
   input  logic [2:0]       op,
   input  logic             cond_ok,
   input  logic [7:0]       data_in,
   input  logic [2:0]       rst_vec,
   input  logic [1:0]       out_sel,
   input  logic [1:0]       cycle_type,
   output logic [7:0]       addr_out,
   output logic             addr_oe,
   output logic [AW-1:0]    pc,
   output logic [PTR_W-1:0] sp,
   output logic [PTR_W:0]   depth,
   output logic             ovf,
   output logic             unf
);

   // Handshake: op_valid qualifies op/cond_ok/data_in/rst_vec for the single
   // clk edge where it is high. There is no ready; every op is accepted.

   localparam logic [PTR_W:0] DEPTH_MAX = (PTR_W+1)'(DEPTH - 1);

   logic [AW-1:0]    tmp, tmp_nxt;
   logic [PTR_W-1:0] sp_nxt;
   logic [PTR_W:0]   depth_nxt;
   logic             ovf_nxt, unf_nxt;
   logic             we;
   logic [PTR_W-1:0] wr_addr;
   logic [AW-1:0]    wr_data;
   logic             do_push;
   logic [AW-1:0]    push_target;
   logic             unused_data_hi;

   assign unused_data_hi = ^data_in[7:AW-8];

   addr_stack_ctrl_mem #(.AW(AW), .DEPTH(DEPTH), .PTR_W(PTR_W)) u_mem (
      .clk     (clk),
      .rst     (rst),
      .rd_addr (sp),
      .rd_data (pc),
      .we      (we),
      .wr_addr (wr_addr),
      .wr_data (wr_data)
   );

   always_comb begin
      tmp_nxt     = tmp;
      sp_nxt      = sp;
      depth_nxt   = depth;
      ovf_nxt     = ovf;
      unf_nxt     = unf;
      we          = 1'b0;
      wr_addr     = sp;
      wr_data     = pc;
      do_push     = 1'b0;
      push_target = tmp;
      if (op_valid) begin
         case (addr_op_t'(op))
            OP_INC: begin
               we      = 1'b1;
               wr_data = pc + 1'b1;
            end
            OP_LD_LO: tmp_nxt[7:0] = data_in;
            OP_LD_HI: tmp_nxt[AW-1:8] = data_in[AW-9:0];
            OP_JUMP: begin
               we      = cond_ok;
               wr_data = tmp;
            end
            OP_CALL: do_push = cond_ok;
            OP_RET: begin
               if (cond_ok) begin
                  sp_nxt = sp - 1'b1;
                  if (depth == '0) unf_nxt = 1'b1;
                  else             depth_nxt = depth - 1'b1;
               end
            end
            OP_RST: begin
               do_push     = 1'b1;
               push_target = AW'(rst_vec) << RST_VEC_SHIFT;
            end
            default: ;
         endcase
      end
      // Old slot keeps the already-incremented PC as the return address
      if (do_push) begin
         sp_nxt  = sp + 1'b1;
         we      = 1'b1;
         wr_addr = sp + 1'b1;
         wr_data = push_target;
         if (depth == DEPTH_MAX) ovf_nxt = 1'b1;
         else                    depth_nxt = depth + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tmp   <= '0;
         sp    <= '0;
         depth <= '0;
         ovf   <= 1'b0;
         unf   <= 1'b0;
      end else begin
         tmp   <= tmp_nxt;
         sp    <= sp_nxt;
         depth <= depth_nxt;
         ovf   <= ovf_nxt;
         unf   <= unf_nxt;
      end
   end

   always_comb begin
      addr_out = 8'h00;
      addr_oe  = 1'b0;
      case (addr_sel_t'(out_sel))
         SEL_LOW: begin
            addr_out = pc[7:0];
            addr_oe  = 1'b1;
         end
         SEL_HIGH: begin
            addr_out = {cycle_type, pc[AW-1:8]};
            addr_oe  = 1'b1;
         end
         default: ;
      endcase
   end

endmodule
